// File: rtl/digits_to_word_if.sv
// Digit-stream input and result-word output bundle between the UART
// character decoder, the digit accumulator and the RPN stack.
interface digits_to_word_if #(
  parameter int unsigned WIDTH = 16
);
  // Digit/sign/flush side
  logic [3:0]       digit;
  logic             wen;
  logic             minus;
  logic             hex;
  logic             flush;
  logic             in_ready;
  // Result side
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             err;

  modport master (
    output digit, wen, minus, hex, flush, out_ready,
    input  in_ready, dout, out_valid, overflow, err
  );

  modport slave (
    input  digit, wen, minus, hex, flush, out_ready,
    output in_ready, dout, out_valid, overflow, err
  );
endinterface

// File: rtl/digits_to_word.sv
// Accumulates signed decimal/hex digit nibbles into a saturating WIDTH-bit
// two's-complement word and presents it over a valid/ready handshake.
module digits_to_word #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  digits_to_word_if.slave bus
);

  localparam int unsigned AW = WIDTH + 4;
  localparam logic [WIDTH-1:0] LIMIT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             neg_q, neg_d;
  logic             hex_q, hex_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             radix_hex;
  logic             digit_ok;
  logic [AW-1:0]    prod;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dout_q  <= '0;
      neg_q   <= 1'b0;
      hex_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dout_q  <= dout_d;
      neg_q   <= neg_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next state: sign, then digit, then flush are applied in that order within a cycle
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    dout_d    = dout_q;
    neg_d     = neg_q;
    hex_d     = hex_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    radix_hex = hex_q;
    digit_ok  = 1'b0;
    prod      = '0;

    case (state_q)
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          mag_d   = '0;
          dout_d  = '0;
          neg_d   = 1'b0;
          hex_d   = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        if (state_q == IDLE && (bus.wen || bus.minus)) begin
          hex_d     = bus.hex;
          radix_hex = bus.hex;
          state_d   = ACCUM;
        end

        if (bus.minus) begin
          if (state_q == IDLE) neg_d = 1'b1;
          else                 err_d = 1'b1;
        end

        // Magnitude freezes once it passes 2^(WIDTH-1); range checks continue
        if (bus.wen) begin
          digit_ok = radix_hex || (bus.digit <= 4'd9);
          if (!digit_ok) begin
            err_d = 1'b1;
          end else if (!ovf_q) begin
            prod = (radix_hex ? (AW'(mag_q) << 4) : (AW'(mag_q) * AW'(10)))
                   + AW'(bus.digit);
            if (prod > AW'(LIMIT)) ovf_d = 1'b1;
            else                   mag_d = prod[WIDTH-1:0];
          end
        end

        // A magnitude of exactly 2^(WIDTH-1) is only representable when negative
        if (bus.flush && (state_q == ACCUM || bus.wen || bus.minus)) begin
          state_d = HOLD;
          if (ovf_d) begin
            dout_d = neg_d ? LIMIT : MAX_POS;
          end else if (neg_d) begin
            dout_d = -mag_d;
          end else if (mag_d == LIMIT) begin
            ovf_d  = 1'b1;
            dout_d = MAX_POS;
          end else begin
            dout_d = mag_d;
          end
        end
      end
    endcase
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.dout      = dout_q;
  assign bus.overflow  = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_digits_to_word.sv
// Directed bench for digits_to_word: an arithmetic reference model checked
// every cycle, plus hand-computed literal results for each scenario.
module tb_digits_to_word;
  localparam int W = 16;
  localparam longint LIM = longint'(1) << (W - 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  digits_to_word_if #(.WIDTH(W)) bus ();

  digits_to_word #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the number as plain integers, evaluated at flush
  bit          m_ok;
  bit          m_busy;
  bit          m_hold;
  bit          m_neg;
  bit          m_hex;
  bit          m_err;
  longint      m_val;
  logic [W-1:0] e_dout;
  bit          e_ovf;

  task automatic model_clear();
    m_busy = 0; m_hold = 0; m_neg = 0; m_hex = 0; m_err = 0; m_val = 0;
  endtask

  always @(posedge clk) begin : model
    longint s;
    int     r;
    bit     started;
    if (!rst_n) begin
      model_clear();
      m_ok = 1;
    end else if (m_ok) begin
      if (m_hold) begin
        if (bus.out_ready) model_clear();
      end else begin
        started = m_busy;
        if (!m_busy && (bus.wen || bus.minus)) begin
          m_busy = 1;
          m_hex  = bus.hex;
        end
        if (bus.minus) begin
          if (!started) m_neg = 1;
          else          m_err = 1;
        end
        if (bus.wen) begin
          r = m_hex ? 16 : 10;
          if (int'(bus.digit) >= r) m_err = 1;
          else begin
            m_val = m_val * r + longint'(bus.digit);
            if (m_val > LIM) m_val = LIM + 1;
          end
        end
        if (bus.flush && m_busy) begin
          s     = m_neg ? -m_val : m_val;
          e_ovf = (s > LIM - 1) || (s < -LIM);
          if (s > LIM - 1)   s = LIM - 1;
          else if (s < -LIM) s = -LIM;
          e_dout = W'(s);
          m_hold = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && rst_n) begin
      chk("mdl_in_ready", 32'(bus.in_ready), 32'(!m_hold));
      chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("mdl_dout", 32'(bus.dout), 32'(e_dout));
        chk("mdl_overflow", 32'(bus.overflow), 32'(e_ovf));
        chk("mdl_err", 32'(bus.err), 32'(m_err));
      end
    end
  end

  // One clock with the given inputs held across the edge
  task automatic cyc(input logic [3:0] d, input logic w, input logic m,
                     input logic h, input logic f, input logic r);
    bus.digit = d; bus.wen = w; bus.minus = m;
    bus.hex = h; bus.flush = f; bus.out_ready = r;
    @(posedge clk);
    #1;
    bus.wen = 1'b0; bus.minus = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d, input logic h);
    cyc(d, 1'b1, 1'b0, h, 1'b0, 1'b0);
  endtask

  task automatic flush_now();
    cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_res(input string nm, input logic [W-1:0] d,
                            input logic o, input logic e);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_dout"}, 32'(bus.dout), 32'(d));
    chk({nm, "_ovf"}, 32'(bus.overflow), 32'(o));
    chk({nm, "_err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic accept(input string nm);
    cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({nm, "_drop"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; m_ok = 0;
    rst_n = 1'b0;
    bus.digit = '0; bus.wen = 0; bus.minus = 0; bus.hex = 0;
    bus.flush = 0; bus.out_ready = 0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    dig(1, 0); dig(2, 0); dig(3, 0); flush_now();
    expect_res("dec123", 16'h007B, 0, 0);
    accept("dec123");

    cyc(0, 0, 1, 0, 0, 0); dig(4, 0); flush_now();
    expect_res("neg4", 16'hFFFC, 0, 0);
    accept("neg4");

    dig(7, 1); dig(4'hF, 1); dig(4'hF, 1); dig(4'hF, 1); flush_now();
    expect_res("hex7fff", 16'h7FFF, 0, 0);
    accept("hex7fff");

    dig(8, 1); dig(0, 1); dig(0, 1); dig(0, 1); flush_now();
    expect_res("hex8000", 16'h7FFF, 1, 0);
    accept("hex8000");

    dig(3, 0); dig(2, 0); dig(7, 0); dig(6, 0); dig(8, 0); flush_now();
    expect_res("dec32768", 16'h7FFF, 1, 0);
    accept("dec32768");

    cyc(0, 0, 1, 0, 0, 0);
    dig(3, 0); dig(2, 0); dig(7, 0); dig(6, 0); dig(8, 0); flush_now();
    expect_res("decm32768", 16'h8000, 0, 0);
    accept("decm32768");

    for (int i = 0; i < 6; i++) dig(9, 0);
    flush_now();
    expect_res("dec999999", 16'h7FFF, 1, 0);
    accept("dec999999");

    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) dig(9, 0);
    flush_now();
    expect_res("negovf", 16'h8000, 1, 0);
    accept("negovf");

    dig(1, 0); dig(4'hA, 0); dig(2, 0); flush_now();
    expect_res("baddigit", 16'h000C, 0, 1);
    accept("baddigit");

    dig(5, 0); cyc(0, 0, 1, 0, 0, 0); flush_now();
    expect_res("lateminus", 16'h0005, 0, 1);
    accept("lateminus");

    flush_now();
    chk("idle_flush", 32'(bus.out_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_flush2", 32'(bus.out_valid), 32'd0);

    cyc(0, 0, 1, 0, 1, 0);
    expect_res("minusonly", 16'h0000, 0, 0);
    accept("minusonly");

    cyc(4, 1, 1, 0, 0, 0); flush_now();
    expect_res("minuswen", 16'hFFFC, 0, 0);
    accept("minuswen");

    dig(3, 0); cyc(4, 1, 0, 0, 1, 0);
    expect_res("wenflush", 16'h0022, 0, 0);
    accept("wenflush");

    dig(1, 1); dig(4'hF, 0); flush_now();
    expect_res("hexlatch", 16'h001F, 0, 0);
    accept("hexlatch");

    dig(6, 0); dig(6, 0); flush_now();
    expect_res("bp", 16'h0042, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(9, 1'(i % 2 == 0), 0, 0, 1'(i % 2 == 1), 0);
      chk("bp_dout", 32'(bus.dout), 32'h0042);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    cyc(9, 1, 0, 0, 1, 1);
    chk("bp_xfer", 32'(bus.out_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_single", 32'(bus.out_valid), 32'd0);
    dig(1, 0); flush_now();
    expect_res("bp_after", 16'h0001, 0, 0);
    accept("bp_after");

    dig(1, 0); dig(2, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_ready", 32'(bus.in_ready), 32'd1);
    chk("rstmid_dout", 32'(bus.dout), 32'd0);
    dig(7, 0); flush_now();
    expect_res("rstmid", 16'h0007, 0, 0);

    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rsthold_valid", 32'(bus.out_valid), 32'd0);
    chk("rsthold_dout", 32'(bus.dout), 32'd0);
    chk("rsthold_ovf", 32'(bus.overflow), 32'd0);

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
